// File: rtl/systolic_feeder.sv
// Operand sequencer for an NxN systolic matmul array: captures A/B on start,
// clears the accumulators, then streams diagonally skewed rows/columns with zero padding.
module systolic_feeder_lane #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int TW   = 4,
    parameter int LANE = 0
) (
    input  logic [N-1:0][DW-1:0] vec,
    input  logic [TW-1:0]        t,
    output logic [DW-1:0]        elem
);
    // Lane LANE carries element k at step t = LANE + k; every other step is padding.
    always_comb begin
        elem = '0;
        for (int k = 0; k < N; k++)
            if (int'(t) == LANE + k) elem = vec[k];
    end
endmodule

module systolic_feeder #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int PE_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N-1:0][N-1:0][DW-1:0] A_mat,
    input  logic [N-1:0][N-1:0][DW-1:0] B_mat,
    output logic [N-1:0][DW-1:0]       A_out,
    output logic [N-1:0][DW-1:0]       B_out,
    output logic                       clr_pe,
    output logic                       busy,
    output logic                       done
);
    localparam int FEED_LEN = 3 * N - 2;
    localparam int TW       = $clog2(FEED_LEN);
    localparam int DCW      = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t                       state;
    logic [N-1:0][N-1:0][DW-1:0]  a_cap, b_cap, b_cols;
    logic [TW-1:0]                t, t_nxt;
    logic [DCW-1:0]               dcnt;
    logic [N-1:0][DW-1:0]         a_lane, b_lane;

    // Outputs are registered, so lanes look up the step being loaded, not the current one.
    assign t_nxt = (state == CLEAR) ? '0 : t + 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_lane
        for (genvar k = 0; k < N; k++) begin : g_col
            assign b_cols[i][k] = b_cap[k][i];
        end
        systolic_feeder_lane #(.N(N), .DW(DW), .TW(TW), .LANE(i)) u_a (
            .vec(a_cap[i]), .t(t_nxt), .elem(a_lane[i]));
        systolic_feeder_lane #(.N(N), .DW(DW), .TW(TW), .LANE(i)) u_b (
            .vec(b_cols[i]), .t(t_nxt), .elem(b_lane[i]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            t      <= '0;
            dcnt   <= '0;
            A_out  <= '0;
            B_out  <= '0;
            clr_pe <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            clr_pe <= 1'b0;
            done   <= 1'b0;
            A_out  <= '0;
            B_out  <= '0;
            case (state)
                IDLE: if (start) begin
                    a_cap  <= A_mat;
                    b_cap  <= B_mat;
                    state  <= CLEAR;
                    clr_pe <= 1'b1;
                    busy   <= 1'b1;
                end
                CLEAR: begin
                    state <= FEED;
                    t     <= '0;
                    A_out <= a_lane;
                    B_out <= b_lane;
                end
                FEED: begin
                    if (t == TW'(FEED_LEN - 1)) begin
                        if (PE_LAT == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                            dcnt  <= '0;
                        end
                    end else begin
                        t     <= t_nxt;
                        A_out <= a_lane;
                        B_out <= b_lane;
                    end
                end
                DRAIN: begin
                    if (dcnt == DCW'(PE_LAT - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    t     <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: per-cycle stream checks against the skew rule and
// a dataflow model of the array that must reproduce the plain matrix product.
module tb_systolic_feeder;
    localparam int N = 4, DW = 8, PE_LAT = 1;
    localparam int FL = 3 * N - 2;
    localparam int L  = 3 * N + PE_LAT;   // done cycle relative to accept
    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

    logic clk = 0, rst = 1, start = 1;
    mat_t A_mat = '0, B_mat = '0;
    logic [N-1:0][DW-1:0] A_out, B_out;
    logic clr_pe, busy, done;
    int errors = 0, checks = 0;
    int sa [FL][N];
    int sb [FL][N];

    systolic_feeder #(.N(N), .DW(DW), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .A_mat(A_mat), .B_mat(B_mat),
        .A_out(A_out), .B_out(B_out), .clr_pe(clr_pe), .busy(busy), .done(done));

    always #5 clk = ~clk;

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) m[i][k] = DW'($urandom_range(0, 255));
        return m;
    endfunction

    task automatic check_idle(input string name);
        checks++;
        if ({busy, clr_pe, done, A_out, B_out} !== '0) begin
            errors++;
            $display("FAIL %s: got busy=%b clr=%b done=%b A=%h B=%h, want all zero",
                     name, busy, clr_pe, done, A_out, B_out);
        end
    endtask

    // Runs one job from IDLE; caller is at a negedge. After the accept edge the
    // input matrices are switched to nxa/nxb so the captured copy is what gets checked.
    task automatic run_job(input string name, input mat_t ma, input mat_t mb,
                           input mat_t nxa, input mat_t nxb, input bit hold,
                           input int mid_k, input int abort_k);
        logic [N-1:0][DW-1:0] ea, eb;
        logic eb_busy, eclr, edone;
        longint c, ref_c;
        start = 1; A_mat = ma; B_mat = mb;
        @(posedge clk);
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin A_mat = nxa; B_mat = nxb; start = hold; end
            if (mid_k > 0 && k == mid_k) start = 1;
            if (mid_k > 0 && k == mid_k + 1) start = 0;
            ea = '0; eb = '0;
            eb_busy = (k <= L); eclr = (k == 1); edone = (k == L);
            if (k >= 2 && k <= FL + 1) begin
                int t = k - 2;
                for (int i = 0; i < N; i++) begin
                    if (t - i >= 0 && t - i < N) ea[i] = ma[i][t - i];
                    if (t - i >= 0 && t - i < N) eb[i] = mb[t - i][i];
                    sa[t][i] = int'(A_out[i]);
                    sb[t][i] = int'(B_out[i]);
                end
            end
            checks++;
            if ({busy, clr_pe, done, A_out, B_out} !== {eb_busy, eclr, edone, ea, eb}) begin
                errors++;
                $display("FAIL %s cycle %0d: got busy=%b clr=%b done=%b A=%h B=%h, want busy=%b clr=%b done=%b A=%h B=%h",
                         name, k, busy, clr_pe, done, A_out, B_out, eb_busy, eclr, edone, ea, eb);
            end
            if (k == abort_k) begin
                rst = 1; start = 0;
                @(posedge clk); @(negedge clk);
                check_idle({name, " after abort"});
                rst = 0;
                return;
            end
        end
        // PE(i,j) sees row stream i delayed j cycles and column stream j delayed i.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                c = 0; ref_c = 0;
                for (int t = 0; t < FL + 2 * N; t++)
                    if (t - j >= 0 && t - j < FL && t - i >= 0 && t - i < FL)
                        c += longint'(sa[t - j][i]) * longint'(sb[t - i][j]);
                for (int k = 0; k < N; k++) ref_c += longint'(ma[i][k]) * longint'(mb[k][j]);
                checks++;
                if (c !== ref_c) begin
                    errors++;
                    $display("FAIL %s C[%0d][%0d]: got %0d, want %0d", name, i, j, c, ref_c);
                end
            end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk);
            check_idle("reset");
        end
        rst = 0; start = 0;
        @(posedge clk); @(negedge clk);
        check_idle("after reset");
    endtask

    task automatic test_identity();
        mat_t ia = '0, bb;
        for (int i = 0; i < N; i++) begin
            ia[i][i] = 8'd1;
            for (int j = 0; j < N; j++) bb[i][j] = DW'(4 * i + j + 1);
        end
        run_job("identity", ia, bb, rand_mat(), rand_mat(), 0, 0, 0);
    endtask

    task automatic test_skew();
        mat_t sk;
        int exp2 [FL] = '{0, 0, 33, 34, 35, 36, 0, 0, 0, 0};
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) sk[i][k] = DW'(16 * i + k + 1);
        run_job("skew", sk, rand_mat(), rand_mat(), rand_mat(), 0, 0, 0);
        for (int t = 0; t < FL; t++) begin
            checks++;
            if (sa[t][2] != exp2[t]) begin
                errors++;
                $display("FAIL skew A_out[2] t=%0d: got %0d, want %0d", t, sa[t][2], exp2[t]);
            end
        end
        for (int t = 0; t < N; t++) begin
            checks++;
            if (sa[t][0] != t + 1) begin
                errors++;
                $display("FAIL skew A_out[0] t=%0d: got %0d, want %0d", t, sa[t][0], t + 1);
            end
        end
    endtask

    task automatic test_full_scale();
        mat_t f = '1;
        run_job("full_scale", f, f, rand_mat(), rand_mat(), 0, 6, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_idle("full_scale trailing");
        end
    endtask

    task automatic test_back_to_back();
        mat_t a1 = rand_mat(), b1 = rand_mat(), a2 = rand_mat(), b2 = rand_mat();
        run_job("b2b first", a1, b1, a2, b2, 1, 0, 0);
        run_job("b2b second", a2, b2, rand_mat(), rand_mat(), 0, 0, 0);
    endtask

    task automatic test_abort();
        run_job("abort", rand_mat(), rand_mat(), rand_mat(), rand_mat(), 0, 0, 6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle("abort idle");
        end
        run_job("after abort", rand_mat(), rand_mat(), rand_mat(), rand_mat(), 0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++)
            run_job("random", rand_mat(), rand_mat(), rand_mat(), rand_mat(), 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_skew();
        test_full_scale();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, want completion");
        $fatal(1, "timeout");
    end
endmodule
